// File: rtl/pru_pkg.sv
// Shared PRU definitions: beat width, head-beat field map and arbiter FSM states.
package pru_pkg;

    localparam int PW      = 128;
    localparam int TYPE_HI = 127;
    localparam int TYPE_LO = 122;
    localparam int SZ_HI   = 121;
    localparam int SZ_LO   = 114;
    localparam int SRC_HI  = 63;
    localparam int SRC_LO  = 32;
    localparam int TRGT_HI = 31;
    localparam int TRGT_LO = 0;
    localparam int SW      = SZ_HI - SZ_LO + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/pru_rr_pick.sv
// Request picker: first requester at or after ptr (MODE 0) or lowest index (MODE 1).
module pru_rr_pick #(
    parameter int NP   = 17,
    parameter int MODE = 0,
    parameter int IW   = $clog2(NP)
) (
    input  logic [NP-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic [NP-1:0] gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan NP slots starting at the base, wrapping once; first hit wins.
    always_comb begin
        int base;
        int j;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        base = (MODE == 1) ? 0 : int'(ptr);
        j    = 0;
        for (int k = 0; k < NP; k++) begin
            j = base + k;
            if (j >= NP) j = j - NP;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/pru_arb_in_rr.sv
// N-port packet arbiter: packet-locked grant, registered single output stream.
module pru_arb_in_rr
    import pru_pkg::*;
#(
    parameter int NP    = 17,
    parameter int PW    = pru_pkg::PW,
    parameter int MODE  = 0,
    parameter int SZ_HI = pru_pkg::SZ_HI,
    parameter int SZ_LO = pru_pkg::SZ_LO,
    parameter int IW    = $clog2(NP)
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [NP-1:0]    iPort_vld,
    input  logic [NP*PW-1:0] iPort_pkt,
    output logic [NP-1:0]    oPort_ack,
    output logic             oArb_vld,
    output logic [PW-1:0]    oArb_pkt,
    output logic [IW-1:0]    oArb_src,
    output logic             oArb_sop,
    output logic             oArb_eop,
    input  logic             iArb_ack
);

    localparam int CW = SZ_HI - SZ_LO + 1;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q,   ptr_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          vld_q,   vld_d;
    logic [PW-1:0] pkt_q,   pkt_d;
    logic [IW-1:0] src_q,   src_d;
    logic          sop_q,   sop_d;
    logic          eop_q,   eop_d;

    logic [NP-1:0] win_gnt;
    logic [IW-1:0] win_idx;
    logic          win_any;
    logic [IW-1:0] sel_idx;
    logic          sel_any;
    logic          slot_free;
    logic [NP-1:0] ack;
    logic          accept;
    logic          last;
    logic [PW-1:0] pkt_in;
    logic [CW-1:0] head_sz;

    pru_rr_pick #(.NP(NP), .MODE(MODE), .IW(IW)) u_pick (
        .req (iPort_vld),
        .ptr (ptr_q),
        .gnt (win_gnt),
        .idx (win_idx),
        .any (win_any)
    );

    // Grant selection, port acks and next-state for FSM, pointer and output register.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        vld_d     = vld_q;
        pkt_d     = pkt_q;
        src_d     = src_q;
        sop_d     = sop_q;
        eop_d     = eop_q;

        // While a packet is in flight only its owner may move beats.
        sel_idx   = (state_q == IDLE) ? win_idx : owner_q;
        sel_any   = (state_q == IDLE) ? win_any : 1'b1;
        slot_free = ~vld_q | iArb_ack;
        ack       = (slot_free && sel_any && !iRst) ? (iPort_vld & (NP'(1) << sel_idx)) : '0;
        accept    = |ack;
        pkt_in    = iPort_pkt[sel_idx*PW +: PW];
        head_sz   = pkt_in[SZ_HI:SZ_LO];
        last      = (state_q == IDLE) ? (head_sz == '0) : (cnt_q == CW'(1));

        if (slot_free) vld_d = 1'b0;

        if (accept) begin
            vld_d = 1'b1;
            pkt_d = pkt_in;
            src_d = sel_idx;
            eop_d = last;
            if (state_q == IDLE) begin
                owner_d = sel_idx;
                cnt_d   = head_sz;
                sop_d   = 1'b1;
                if (!last) state_d = BUSY;
            end else begin
                cnt_d = cnt_q - CW'(1);
                sop_d = 1'b0;
                if (last) state_d = IDLE;
            end
            if (last && MODE == 0)
                ptr_d = (sel_idx == IW'(NP - 1)) ? '0 : sel_idx + IW'(1);
        end
    end

    // State and output register; reset drops any partial packet.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            pkt_q   <= '0;
            src_q   <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            pkt_q   <= pkt_d;
            src_q   <= src_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    assign oPort_ack = ack;
    assign oArb_vld  = vld_q;
    assign oArb_pkt  = pkt_q;
    assign oArb_src  = src_q;
    assign oArb_sop  = sop_q;
    assign oArb_eop  = eop_q;

endmodule
